demux2_stream: RTL and testbench

//  Write-side counterpart of the 2:1 select mux. It accepts one 32-bit word
//  per handshake and steers it to output port A (choose=0) or B (choose=1).

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_slot.sv | 80 ++++++++
 rtl/demux2_stream.sv | 90 +++++++++
 tb/tb_demux2_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and defaults for the demux2_stream write-side demultiplexer.
// The transfer counters are built only when DEMUX_CNT_EN is defined.
package demux_pkg;

   localparam int DEMUX_WIDTH_DEF = 32;
   localparam int DEMUX_CNT_W_DEF = 16;

   // One-entry output slot: either holds a word for its sink or does not.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_st_t;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with load/drain and slot state.
// The slot state is exported so the parent can derive valid from it and so
// checkers can watch it. Optional delivered-word counter under DEMUX_CNT_EN.
//
// Handshake: a word moves across an interface on a cycle where its valid
// and ready are both 1 at the rising edge. While valid=1 and ready=0 the
// producer holds valid and data stable.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH_DEF
`ifdef DEMUX_CNT_EN
   ,
   parameter int CNT_W = DEMUX_CNT_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             sink_ready,
   output slot_st_t         st,
   output logic [WIDTH-1:0] data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt
`endif
);

   slot_st_t         st_q, st_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             drain;

   assign drain = (st_q == SLOT_FULL) && sink_ready;

   // Next slot state and contents: a load always wins, a lone drain empties.
   always_comb begin
      st_d   = st_q;
      data_d = data_q;
      if (load) begin
         st_d   = SLOT_FULL;
         data_d = load_data;
      end else if (drain) begin
         st_d = SLOT_EMPTY;
      end
   end

   // Slot state and word register; reset discards any buffered word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= SLOT_EMPTY;
         data_q <= '0;
      end else begin
         st_q   <= st_d;
         data_q <= data_d;
      end
   end

   assign st   = st_q;
   assign data = data_q;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count delivered words; wraps naturally at 2^CNT_W.
   always_comb begin
      cnt_d = cnt_q;
      if (drain) cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: steers one upstream word per handshake to slot A
// (choose=0) or slot B (choose=1). A stalled sink blocks only words
// addressed to it; the other slot keeps draining.
// Optional feature macro: DEMUX_CNT_EN adds a_cnt/b_cnt delivered counters.
//
// Handshake: a word transfers on a rising edge where valid & ready. in_ready
// depends only on choose and the selected slot's occupancy/sink ready, never
// on in_valid. Upstream holds in_data/choose while in_valid & ~in_ready.
module demux2_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH_DEF
`ifdef DEMUX_CNT_EN
   ,
   parameter int CNT_W = DEMUX_CNT_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             choose,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] a_cnt,
   output logic [CNT_W-1:0] b_cnt
`endif
);

   slot_st_t a_st;
   slot_st_t b_st;
   logic     accept;
   logic     a_load;
   logic     b_load;

   assign a_valid = (a_st == SLOT_FULL);
   assign b_valid = (b_st == SLOT_FULL);

   // Selected slot can take a word if it is empty or emptying this cycle.
   always_comb begin
      in_ready = choose ? (~b_valid | b_ready) : (~a_valid | a_ready);
      accept   = in_valid & in_ready;
      a_load   = accept & ~choose;
      b_load   = accept & choose;
   end

   demux_slot #(
      .WIDTH(WIDTH)
`ifdef DEMUX_CNT_EN
      , .CNT_W(CNT_W)
`endif
   ) u_slot_a (
      .clk       (clk),
      .rst       (rst),
      .load      (a_load),
      .load_data (in_data),
      .sink_ready(a_ready),
      .st        (a_st),
      .data      (a_data)
`ifdef DEMUX_CNT_EN
      , .cnt     (a_cnt)
`endif
   );

   demux_slot #(
      .WIDTH(WIDTH)
`ifdef DEMUX_CNT_EN
      , .CNT_W(CNT_W)
`endif
   ) u_slot_b (
      .clk       (clk),
      .rst       (rst),
      .load      (b_load),
      .load_data (in_data),
      .sink_ready(b_ready),
      .st        (b_st),
      .data      (b_data)
`ifdef DEMUX_CNT_EN
      , .cnt     (b_cnt)
`endif
   );

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed scenarios followed by constrained-random
// traffic, checked against a queue-based model of the two output slots.
module tb_demux2_stream;

   localparam int W        = 32;
   localparam int TB_CNT_W = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          choose = 1'b0;
   logic          a_valid;
   logic          a_ready = 1'b0;
   logic [W-1:0]  a_data;
   logic          b_valid;
   logic          b_ready = 1'b0;
   logic [W-1:0]  b_data;
`ifdef DEMUX_CNT_EN
   logic [TB_CNT_W-1:0] a_cnt;
   logic [TB_CNT_W-1:0] b_cnt;
`endif

   // clock / reset block
   always #5 clk = ~clk;

   demux2_stream #(
      .WIDTH(W)
`ifdef DEMUX_CNT_EN
      , .CNT_W(TB_CNT_W)
`endif
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data (in_data),
      .choose  (choose),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_data  (a_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_data  (b_data)
`ifdef DEMUX_CNT_EN
      , .a_cnt (a_cnt)
      , .b_cnt (b_cnt)
`endif
   );

   // scoreboard: each slot is a queue holding at most one pending word
   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];
   int           exp_a_cnt = 0;
   int           exp_b_cnt = 0;
   logic         exp_ready = 1'b1;
   int           accepts = 0;
   int           checks = 0;
   int           failures = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against the model for the current inputs.
   task automatic model_check();
      logic a_room, b_room;
      a_room    = (exp_a_q.size() == 0) || a_ready;
      b_room    = (exp_b_q.size() == 0) || b_ready;
      exp_ready = choose ? b_room : a_room;
      chk("in_ready", W'(in_ready), W'(exp_ready));
      chk("a_valid", W'(a_valid), W'(exp_a_q.size() != 0));
      chk("b_valid", W'(b_valid), W'(exp_b_q.size() != 0));
      if (exp_a_q.size() != 0) chk("a_data", a_data, exp_a_q[0]);
      if (exp_b_q.size() != 0) chk("b_data", b_data, exp_b_q[0]);
`ifdef DEMUX_CNT_EN
      chk("a_cnt", W'(a_cnt), W'(exp_a_cnt));
      chk("b_cnt", W'(b_cnt), W'(exp_b_cnt));
`endif
   endtask

   // Apply the transfers that happen at the rising edge to the model.
   task automatic model_update();
      if (exp_a_q.size() != 0 && a_ready) begin
         void'(exp_a_q.pop_front());
         exp_a_cnt = (exp_a_cnt + 1) % (1 << TB_CNT_W);
      end
      if (exp_b_q.size() != 0 && b_ready) begin
         void'(exp_b_q.pop_front());
         exp_b_cnt = (exp_b_cnt + 1) % (1 << TB_CNT_W);
      end
      if (in_valid && exp_ready) begin
         accepts++;
         if (choose) exp_b_q.push_back(in_data);
         else        exp_a_q.push_back(in_data);
      end
   endtask

   // One cycle: inputs were set after a falling edge; check, clock, advance.
   task automatic tick();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic c,
                        input logic ar, input logic br);
      in_valid = v;
      in_data  = d;
      choose   = c;
      a_ready  = ar;
      b_ready  = br;
   endtask

   initial begin : stim
      int acc0;
      logic hold;

      // reset values while rst is held
      #2;
      chk("rst_a_valid", W'(a_valid), '0);
      chk("rst_b_valid", W'(b_valid), '0);
      chk("rst_a_data", a_data, '0);
      chk("rst_b_data", b_data, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // steering: 0x11 to A then 0x22 to B, sinks ready
      drive(1'b1, 32'h11, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 32'h22, 1'b1, 1'b1, 1'b1);
      #1;
      chk("steer_a_valid", W'(a_valid), 32'h1);
      chk("steer_a_data", a_data, 32'h11);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("steer_b_data", b_data, 32'h22);
      chk("steer_a_gone", W'(a_valid), 32'h0);
      tick();
      chk("steer_b_gone", W'(b_valid), 32'h0);
      tick();

      // stall isolation: A stuck full with 0xAA, B keeps flowing
      drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'hCC, 1'b0, 1'b0, 1'b1);
      #1;
      chk("stall_ready_a", W'(in_ready), 32'h0);
      tick();
      drive(1'b1, 32'hBB, 1'b1, 1'b0, 1'b1);
      #1;
      chk("stall_ready_b", W'(in_ready), 32'h1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("stall_b_data", b_data, 32'hBB);
      chk("stall_a_hold", a_data, 32'hAA);
      tick();

      // simultaneous drain + load on A, no bubble
      drive(1'b1, 32'h01, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h02, 1'b0, 1'b1, 1'b0);
      #1;
      chk("dl_first", a_data, 32'h01);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("dl_valid", W'(a_valid), 32'h1);
      chk("dl_data", a_data, 32'h02);
      tick();
      tick();

      // back-to-back: 8 alternating words, both sinks ready
      acc0 = accepts;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h100 + W'(i), i[0], 1'b1, 1'b1);
         tick();
      end
      chk("b2b_accepts", W'(accepts - acc0), 32'd8);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      tick();

      // async reset mid-stream with A full and stalled
      drive(1'b1, 32'h5A5A, 1'b0, 1'b0, 1'b1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_a_valid", W'(a_valid), '0);
      chk("arst_a_data", a_data, '0);
      chk("arst_b_valid", W'(b_valid), '0);
`ifdef DEMUX_CNT_EN
      chk("arst_a_cnt", W'(a_cnt), '0);
      chk("arst_b_cnt", W'(b_cnt), '0);
`endif
      exp_a_q.delete();
      exp_b_q.delete();
      exp_a_cnt = 0;
      exp_b_cnt = 0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // counter wrap: 17 transfers on A
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 32'h200 + W'(i), 1'b0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
`ifdef DEMUX_CNT_EN
      chk("wrap_a_cnt", W'(a_cnt), 32'd1);
`endif

      // random traffic with upstream hold rule honoured
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            choose   = $urandom_range(0, 1);
         end
         a_ready = ($urandom_range(0, 2) != 0);
         b_ready = ($urandom_range(0, 3) == 0);
         tick();
         hold = in_valid && !exp_ready;
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
